reg_to_apb_master: RTL and testbench
====================================

Name: reg_to_apb_master

Overview:
Register-interface responder that bridges to an APB4 completer, initiating one APB transfer per register-bus request. It is the reverse of the APB-to-register path: register-bus masters (control FSMs, debug logic) reach APB peripherals through it. It handles one request at a time, supports APB wait states and PSLVERR, and has an optional PREADY timeout that prevents bus lock-up.

Parameters:
ADDR_WIDTH, 32, address width of both buses.
DATA_WIDTH, 32, data width of both buses; must be a multiple of 8.
TIMEOUT_CYCLES, 0, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset; synchronous, active-low.
req_valid_i  in  1  register request valid; held high until rsp_ready_o.
req_write_i  in  1  1 = write, 0 = read.
req_addr_i  in  ADDR_WIDTH  request address.
req_wdata_i  in  DATA_WIDTH  write data.
req_wstrb_i  in  DATA_WIDTH/8  byte strobes.
rsp_ready_o  out  1  single-cycle completion pulse.
rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_ready_o.
rsp_error_o  out  1  error flag, valid with rsp_ready_o.
psel_o  out  1  APB select.
penable_o  out  1  APB enable.
pwrite_o  out  1  APB direction.
paddr_o  out  ADDR_WIDTH  APB address.
pwdata_o  out  DATA_WIDTH  APB write data.
pstrb_o  out  DATA_WIDTH/8  APB write strobes.
prdata_i  in  DATA_WIDTH  APB read data.
pready_i  in  1  APB ready.
pslverr_i  in  1  APB error.
busy_o  out  1  high in any state other than IDLE.
timeout_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset is sampled at posedge clk_i while rst_ni = 0. It forces the FSM to IDLE and drives every output to 0, including when asserted mid-transfer. Any in-flight request is dropped with no rsp_ready_o.
- All outputs are registered. The FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE: when req_valid_i = 1, latch write, addr, wdata and wstrb, then go to SETUP. Request inputs are ignored in every other state.
- SETUP (exactly 1 cycle): psel_o = 1, penable_o = 0; paddr_o and pwrite_o come from the latched request. For writes, pwdata_o and pstrb_o carry the latched values; for reads both are 0. Next state is ACCESS.
- ACCESS: psel_o = 1, penable_o = 1, with address, data and controls held stable.
  - pready_i = 1: capture prdata_i and pslverr_i, go to RESP.
  - pready_i = 0: stay in ACCESS and increment the wait counter. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Timeout (TIMEOUT_CYCLES > 0): if ACCESS has lasted TIMEOUT_CYCLES cycles with pready_i = 0 on every one, go to RESP with error = 1 and pulse timeout_o in the RESP cycle. If pready_i = 1 on the final allowed cycle, the normal completion wins.
- RESP (1 cycle): psel_o = 0, penable_o = 0, rsp_ready_o = 1.
  - rsp_error_o = pslverr, or 1 on timeout.
  - rsp_rdata_o = captured prdata for a read with no error; otherwise 0.
  - Next state is IDLE. rsp_ready_o, rsp_error_o and rsp_rdata_o are 0 outside RESP.
- Latency (request first seen at cycle 0, W = wait states): SETUP at cycle 1, ACCESS at cycles 2 to 2+W, rsp_ready_o at cycle 3+W.
- Back-to-back: if req_valid_i is still high in the IDLE cycle after RESP, that request is accepted as a new transaction. Minimum spacing is 4 cycles per transfer.
- No transfer is ever issued without a request; psel_o never rises outside SETUP.
- Addresses pass through unmodified; no alignment check is made.

Test Plan:
- Zero-wait write: addr 0x04, wdata 0xDEADBEEF, wstrb 0xF, pready_i tied to 1 -> psel_o = 1 at cycle 1; penable_o = 1 at cycle 2 with paddr_o = 0x04, pwrite_o = 1, pwdata_o = 0xDEADBEEF; rsp_ready_o = 1 and rsp_error_o = 0 at cycle 3.
- Read with 3 wait states: addr 0x08, pready_i = 1 only at cycle 5 with prdata_i = 0x12345678 -> pwdata_o = 0 and pstrb_o = 0 throughout; rsp_ready_o at cycle 6 with rsp_rdata_o = 0x12345678.
- Read with PSLVERR: pslverr_i = 1 together with pready_i and prdata_i = 0xAAAA5555 -> rsp_error_o = 1, rsp_rdata_o = 0.
- Timeout, TIMEOUT_CYCLES = 8, pready_i held at 0 -> ACCESS at cycles 2 to 9; rsp_ready_o = 1, rsp_error_o = 1 and timeout_o = 1 at cycle 10 with psel_o = 0. Repeat with pready_i = 1 at cycle 9 -> normal completion, timeout_o = 0.
- Back-to-back: req_valid_i held high, with the address switching 0x00 -> 0x04 on the first rsp_ready_o -> second SETUP at cycle 5 with paddr_o = 0x04; exactly two APB transfers observed.
- Reset during ACCESS: rst_ni = 0 for 1 cycle at cycle 3 -> the following cycle psel_o = 0, penable_o = 0, busy_o = 0 and no rsp_ready_o; a subsequent write to 0x00 completes normally.

Source files
------------

// File: rtl/reg_to_apb_master.sv
// Register-bus responder that turns each request into a single APB4 transfer.
// One request in flight at a time; handles wait states, PSLVERR and an optional PREADY timeout.
module reg_to_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                    rsp_ready_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    tmo_q, tmo_d;

    logic                    psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_d;
    logic                    rsp_ready_d, rsp_error_d, timeout_d, busy_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wr_d    = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready completer on the last allowed cycle beats the timeout.
                if (pready_i) begin
                    rdata_d = prdata_i;
                    err_d   = pslverr_i;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output next-values are decoded from the next state so every port is a flop.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        pwrite_d    = psel_d && wr_d;
        paddr_d     = psel_d ? addr_d : '0;
        pwdata_d    = (psel_d && wr_d) ? wdata_d : '0;
        pstrb_d     = (psel_d && wr_d) ? wstrb_d : '0;
        rsp_ready_d = (state_d == RESP);
        rsp_error_d = (state_d == RESP) && err_d;
        timeout_d   = (state_d == RESP) && tmo_d;
        rsp_rdata_d = ((state_d == RESP) && !wr_d && !err_d) ? rdata_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            rsp_ready_o <= 1'b0;
            rsp_error_o <= 1'b0;
            rsp_rdata_o <= '0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            pwrite_o    <= pwrite_d;
            paddr_o     <= paddr_d;
            pwdata_o    <= pwdata_d;
            pstrb_o     <= pstrb_d;
            rsp_ready_o <= rsp_ready_d;
            rsp_error_o <= rsp_error_d;
            rsp_rdata_o <= rsp_rdata_d;
            timeout_o   <= timeout_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_to_apb_master.sv
// Bench for reg_to_apb_master: a cycle-counted APB completer plus a transaction-level
// response model (error = pslverr or timeout, read data only on clean reads).
module tb_reg_to_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;
    localparam int AB  = AW + DW + SW + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_ready, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic          busy, timeout;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    logic psel_prev = 1'b0;

    logic [DW+1:0] exp_q[$];

    reg_to_apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .rsp_ready_o(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (psel && !psel_prev) xfers++;
        psel_prev = psel;
    end

    // One full request; cycle 0 is the IDLE cycle where the request is first presented.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input logic [DW-1:0] rd, input logic serr,
                           input int waits, input logic keep_valid, input string tag);
        logic [AB-1:0] exp_apb, got_apb;
        logic [DW+1:0] exp_rsp, got_rsp;
        logic          tmo, err;
        int            resp_cyc, acc_n;
        @(negedge clk);
        checks++;
        if ({psel, penable, busy, rsp_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle: got psel=%b penable=%b busy=%b rsp_ready=%b, want all 0",
                     tag, psel, penable, busy, rsp_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        tmo      = (waits >= TMO);
        err      = tmo | serr;
        resp_cyc = tmo ? TMO + 2 : waits + 3;
        exp_q.push_back({tmo, err, (!wr && !err) ? rd : {DW{1'b0}}});
        exp_apb  = {1'b1, 1'b0, wr, addr, wr ? wdata : {DW{1'b0}}, wr ? strb : {SW{1'b0}}};
        acc_n    = 0;
        for (int c = 1; c <= resp_cyc; c++) begin
            @(negedge clk);
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            if (c < resp_cyc) begin
                exp_apb[AB-2] = (c >= 2);
                got_apb = {psel, penable, pwrite, paddr, pwdata, pstrb};
                checks++;
                if (got_apb !== exp_apb || busy !== 1'b1 || rsp_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s apb cycle %0d: got %h busy=%b rsp_ready=%b, want %h busy=1 rsp_ready=0",
                             tag, c, got_apb, busy, rsp_ready, exp_apb);
                end
                if (c >= 2) begin
                    if (acc_n == waits) begin
                        pready  = 1'b1;
                        prdata  = rd;
                        pslverr = serr;
                    end
                    acc_n++;
                end
            end else begin
                exp_rsp = exp_q.pop_front();
                got_rsp = {timeout, rsp_error, rsp_rdata};
                checks++;
                if (rsp_ready !== 1'b1 || got_rsp !== exp_rsp || psel !== 1'b0 ||
                    penable !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s resp cycle %0d: got rdy=%b {tmo,err,rdata}=%h psel=%b pen=%b busy=%b, want rdy=1 %h psel=0 pen=0 busy=1",
                             tag, c, rsp_ready, got_rsp, psel, penable, busy, exp_rsp);
                end
                pslverr   = 1'b0;
                prdata    = '0;
                req_valid = keep_valid;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_ready, rsp_error, rsp_rdata, busy, timeout} !== '0) begin
            errors++;
            $display("FAIL reset: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h rdy=%b err=%b rdata=%h busy=%b tmo=%b, want all 0",
                     psel, penable, pwrite, paddr, pwdata, pstrb, rsp_ready, rsp_error, rsp_rdata, busy, timeout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait_write();
        run_txn(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, 1'b0, "zero_wait_write");
    endtask

    task automatic test_wait_read();
        run_txn(1'b0, 32'h08, 32'hCAFEF00D, 4'hF, 32'h12345678, 1'b0, 3, 1'b0, "wait3_read");
    endtask

    task automatic test_slverr();
        run_txn(1'b0, 32'h0C, 32'h0, 4'h0, 32'hAAAA5555, 1'b1, 0, 1'b0, "slverr_read");
        run_txn(1'b1, 32'h10, 32'h55AA00FF, 4'h5, 32'h0, 1'b1, 2, 1'b0, "slverr_write");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, TMO, 1'b0, "timeout");
        run_txn(1'b0, 32'h24, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, TMO - 1, 1'b0, "last_cycle_ready");
    endtask

    task automatic test_back_to_back();
        int x0;
        x0 = xfers;
        run_txn(1'b1, 32'h00, 32'h11111111, 4'hF, 32'h0, 1'b0, 0, 1'b1, "b2b_first");
        run_txn(1'b1, 32'h04, 32'h22222222, 4'hF, 32'h0, 1'b0, 0, 1'b0, "b2b_second");
        repeat (3) @(negedge clk);
        checks++;
        if (xfers - x0 !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d transfers, want 2", xfers - x0);
        end
    endtask

    task automatic test_reset_mid();
        int x0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h33333333;
        req_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({psel, penable, busy, rsp_ready, rsp_error, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid: got psel=%b pen=%b busy=%b rdy=%b err=%b tmo=%b, want all 0",
                     psel, penable, busy, rsp_ready, rsp_error, timeout);
        end
        rst_n = 1'b1;
        x0 = xfers;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_ready !== 1'b0 || xfers !== x0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got rdy=%b new transfers=%0d, want rdy=0 and 0", rsp_ready, xfers - x0);
        end
        run_txn(1'b1, 32'h00, 32'h44444444, 4'hF, 32'h0, 1'b0, 1, 1'b0, "after_reset_write");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 10),
                    1'($urandom_range(0, 1)), "random");
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
